div_issue_ctrl: RTL and testbench

- Upstream sequencer for the single-precision Divider.
- Accepts operand pairs over a valid/ready handshake and drives the Divider's A/B/En pins.
- Waits for Divider completion (Ready edge, NaN flag or timeout), then returns the result over a valid/ready output handshake.
- Only one operation is in flight at a time, and the output is held until it is accepted.

---
 rtl/div_issue_ctrl.sv | 166 ++++++++++++++++
 tb/tb_div_issue_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - single-op issue/complete sequencer for the SP Divider
// Optional special-operand bypass: define DIV_BYPASS_SPECIAL_EN.
module div_issue_ctrl #(
  parameter int EN_CYCLES = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] div_A,
  output logic [31:0] div_B,
  output logic        div_En,
  input  logic [31:0] div_Result,
  input  logic        div_Ready,
  input  logic        div_NaN,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_nan,
  output logic        out_timeout
);

  localparam logic [31:0] QNAN      = 32'h7FC00000;
  localparam logic [7:0]  EN_LAST   = 8'(EN_CYCLES - 1);
  localparam logic [7:0]  TMO_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_rdy_q;
  logic        r_in_ready;
  logic [31:0] r_div_a;
  logic [31:0] r_div_b;
  logic        r_div_en;
  logic        r_out_valid;
  logic [31:0] r_out_result;
  logic        r_out_nan;
  logic        r_out_timeout;

  logic        w_accept;
  logic        w_event;
  logic        w_special;
  logic [31:0] w_spec_result;
  logic        w_spec_nan;

  assign w_accept = in_valid & r_in_ready;
  // Ready is a level that may linger from the previous op, so only its rising edge counts.
  assign w_event  = (div_Ready & ~r_rdy_q) | div_NaN;

`ifdef DIV_BYPASS_SPECIAL_EN
  logic w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero, w_sign;

  always_comb begin
    w_a_nan   = (in_a[30:23] == 8'hFF) && (in_a[22:0] != 23'd0);
    w_b_nan   = (in_b[30:23] == 8'hFF) && (in_b[22:0] != 23'd0);
    w_a_inf   = (in_a[30:23] == 8'hFF) && (in_a[22:0] == 23'd0);
    w_b_inf   = (in_b[30:23] == 8'hFF) && (in_b[22:0] == 23'd0);
    w_a_zero  = (in_a[30:0] == 31'd0);
    w_b_zero  = (in_b[30:0] == 31'd0);
    w_sign    = in_a[31] ^ in_b[31];
    w_special = 1'b1;
    w_spec_nan = 1'b0;
    w_spec_result = 32'd0;
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_spec_result = QNAN;
      w_spec_nan    = 1'b1;
    end else if (w_b_zero || w_a_inf) begin
      w_spec_result = {w_sign, 8'hFF, 23'd0};
    end else if (w_a_zero || w_b_inf) begin
      w_spec_result = {w_sign, 31'd0};
    end else begin
      w_special = 1'b0;
    end
  end
`else
  assign w_special     = 1'b0;
  assign w_spec_result = 32'd0;
  assign w_spec_nan    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_cnt         <= 8'd0;
      r_rdy_q       <= 1'b0;
      r_in_ready    <= 1'b1;
      r_div_a       <= 32'd0;
      r_div_b       <= 32'd0;
      r_div_en      <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_result  <= 32'd0;
      r_out_nan     <= 1'b0;
      r_out_timeout <= 1'b0;
    end else begin
      r_rdy_q <= div_Ready;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_div_a    <= in_a;
            r_div_b    <= in_b;
            r_cnt      <= 8'd0;
            r_in_ready <= 1'b0;
            if (w_special) begin
              r_out_result  <= w_spec_result;
              r_out_nan     <= w_spec_nan;
              r_out_timeout <= 1'b0;
              r_out_valid   <= 1'b1;
              r_state       <= DONE;
            end else begin
              r_div_en <= 1'b1;
              r_state  <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (r_cnt == EN_LAST) begin
            r_div_en <= 1'b0;
            r_cnt    <= 8'd0;
            r_state  <= WAIT;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        WAIT: begin
          if (w_event) begin
            r_out_result  <= div_Result;
            r_out_nan     <= div_NaN;
            r_out_timeout <= 1'b0;
            r_out_valid   <= 1'b1;
            r_state       <= DONE;
          end else if (r_cnt == TMO_LAST) begin
            r_out_result  <= QNAN;
            r_out_nan     <= 1'b1;
            r_out_timeout <= 1'b1;
            r_out_valid   <= 1'b1;
            r_state       <= DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign div_A       = r_div_a;
  assign div_B       = r_div_b;
  assign div_En      = r_div_en;
  assign out_valid   = r_out_valid;
  assign out_result  = r_out_result;
  assign out_nan     = r_out_nan;
  assign out_timeout = r_out_timeout;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - directed self-checking bench for div_issue_ctrl
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = 32'd0;
  logic [31:0] in_b = 32'd0;
  logic [31:0] div_A;
  logic [31:0] div_B;
  logic        div_En;
  logic [31:0] div_Result = 32'd0;
  logic        div_Ready = 1'b0;
  logic        div_NaN = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_nan;
  logic        out_timeout;

  int n_pass = 0;
  int n_total = 0;

  div_issue_ctrl #(.EN_CYCLES(2), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .div_A(div_A), .div_B(div_B), .div_En(div_En),
    .div_Result(div_Result), .div_Ready(div_Ready), .div_NaN(div_NaN),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_nan(out_nan), .out_timeout(out_timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    int en_cnt;
    int bad;
    logic [31:0] held;

    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_div_en", 32'(div_En), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_div_a", div_A, 32'd0);
    step();
    reset = 1'b1;
    step();

    // Basic divide: Ready edge 10 cycles after acceptance
    in_valid = 1'b1; in_a = 32'h40700000; in_b = 32'h3FC00000;
    step();
    in_valid = 1'b0;
    chk("basic_div_a", div_A, 32'h40700000);
    chk("basic_div_b", div_B, 32'h3FC00000);
    en_cnt = 0; bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (div_En) en_cnt++;
      if (in_ready || out_valid) bad++;
      if (i < 9) step();
    end
    chk("basic_en_cycles", 32'(en_cnt), 32'd2);
    chk("basic_busy", 32'(bad), 32'd0);
    div_Result = 32'h40200000; div_Ready = 1'b1;
    step();
    chk("basic_out_valid", 32'(out_valid), 32'd1);
    chk("basic_result", out_result, 32'h40200000);
    chk("basic_nan", 32'(out_nan), 32'd0);
    chk("basic_timeout", 32'(out_timeout), 32'd0);

    // Backpressure: result held, new operands ignored
    held = out_result;
    in_valid = 1'b1; in_a = 32'h12345678; in_b = 32'h9ABCDEF0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_result !== held || !out_valid || in_ready || div_A !== 32'h40700000) bad++;
    end
    chk("bp_stable", 32'(bad), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);

    // Stale Ready: level held high from previous op through launch
    in_valid = 1'b1; in_a = 32'hC0800000; in_b = 32'h3FC00000;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("stale_no_complete", 32'(out_valid), 32'd0);
    div_Ready = 1'b0;
    step(); step();
    chk("stale_after_drop", 32'(out_valid), 32'd0);
    div_Result = 32'hC02AAAAA; div_Ready = 1'b1;
    step();
    chk("stale_out_valid", 32'(out_valid), 32'd1);
    chk("stale_result", out_result, 32'hC02AAAAA);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0; div_Ready = 1'b0;

    // NaN without Ready
    in_valid = 1'b1; in_a = 32'h00000000; in_b = 32'h00000000;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    div_NaN = 1'b1; div_Result = 32'h7FC00001;
    step();
    div_NaN = 1'b0;
    chk("nan_out_valid", 32'(out_valid), 32'd1);
    chk("nan_flag", 32'(out_nan), 32'd1);
    chk("nan_result", out_result, 32'h7FC00001);
    chk("nan_timeout", 32'(out_timeout), 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Timeout: no response; out_valid 64 cycles after WAIT entry
    in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h40000000;
    step();
    in_valid = 1'b0;
    step(); step();
    chk("tmo_en_dropped", 32'(div_En), 32'd0);
    for (int i = 0; i < 63; i++) step();
    chk("tmo_not_yet", 32'(out_valid), 32'd0);
    step();
    chk("tmo_out_valid", 32'(out_valid), 32'd1);
    chk("tmo_result", out_result, 32'h7FC00000);
    chk("tmo_nan", 32'(out_nan), 32'd1);
    chk("tmo_flag", 32'(out_timeout), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset during ISSUE drops div_En without a clock edge
    in_valid = 1'b1; in_a = 32'h40400000; in_b = 32'h3F800000;
    step();
    in_valid = 1'b0;
    chk("rstissue_en_high", 32'(div_En), 32'd1);
    reset = 1'b0;
    #1;
    chk("rstissue_en_async", 32'(div_En), 32'd0);
    step();
    reset = 1'b1;
    step();

    // Reset pulsed in WAIT
    in_valid = 1'b1; in_a = 32'h40400000; in_b = 32'h3F800000;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("rstwait_div_en", 32'(div_En), 32'd0);
    chk("rstwait_out_valid", 32'(out_valid), 32'd0);
    chk("rstwait_in_ready", 32'(in_ready), 32'd1);
    chk("rstwait_div_a", div_A, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
